// File: rtl/ysyx_25020047_lsu_axil_bridge_pkg.sv
// Shared types and codes for the LSU AXI4-Lite bridge and its helpers.
package ysyx_25020047_lsu_axil_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/ysyx_25020047_lsu_align_chk.sv
// Combinational size/address legality check, shared by the LSU and IFU bridges.
module ysyx_25020047_lsu_align_chk
    import ysyx_25020047_lsu_axil_bridge_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic       illegal
);

    always_comb begin
        illegal = 1'b0;
        case (size)
            SZ_B:    illegal = 1'b0;
            SZ_H:    illegal = addr_lo[0];
            SZ_W:    illegal = |addr_lo;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ysyx_25020047_lsu_axil_bridge.sv
// Registered AXI4-Lite master serving one LSU load/store at a time.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | ready for an LSU request
// ST_RD_ADDR | AR valid, waiting for arready
// ST_RD_DATA | rready high, waiting for rvalid
// ST_WR_REQ  | AW and W in flight, each retires independently
// ST_WR_RESP | bready high, waiting for bvalid
// ST_RESP    | response held until the LSU takes it
module ysyx_25020047_lsu_axil_bridge
    import ysyx_25020047_lsu_axil_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [1:0]            req_size,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_W-1:0]     araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [ADDR_W-1:0]     awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    state_t            state;
    logic              req_illegal;
    logic              aw_done;
    logic              w_done;
    logic [ADDR_W-1:0] word_addr;

    ysyx_25020047_lsu_align_chk u_align_chk (
        .size    (req_size),
        .addr_lo (req_addr[1:0]),
        .illegal (req_illegal)
    );

    assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};
    // A channel counts as finished once its valid has dropped or is handshaking now.
    assign aw_done   = !awvalid || awready;
    assign w_done    = !wvalid || wready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            araddr    <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            awaddr    <= '0;
            awvalid   <= 1'b0;
            wdata     <= '0;
            wstrb     <= '0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        araddr    <= word_addr;
                        awaddr    <= word_addr;
                        wdata     <= req_wdata;
                        wstrb     <= req_wmask;
                        rsp_rdata <= '0;
                        if (req_illegal || (req_wen && req_wmask == '0)) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= req_illegal;
                        end else if (req_wen) begin
                            state   <= ST_WR_REQ;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                        end else begin
                            state   <= ST_RD_ADDR;
                            arvalid <= 1'b1;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rdata;
                        rsp_err   <= (rresp != RESP_OKAY);
                        state     <= ST_RESP;
                    end
                end
                ST_WR_REQ: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    if (aw_done && w_done) begin
                        bready <= 1'b1;
                        state  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= (bresp != RESP_OKAY);
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25020047_lsu_axil_bridge.sv
// Bench for the LSU AXI4-Lite bridge: randomized slave timing and requests against a transaction-level model.
module tb_ysyx_25020047_lsu_axil_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wmask = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = '0;
    logic        bvalid = 1'b0;
    logic        bready;

    int checks = 0;
    int errors = 0;

    ysyx_25020047_lsu_axil_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    // slave configuration for the transaction about to be issued
    int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_rresp = '0;
    logic [1:0]  s_bresp = '0;
    logic        lat_chk = 1'b0;

    // transaction-level model
    logic        m_active = 1'b0, m_bus = 1'b0, m_wen = 1'b0, m_err = 1'b0, m_lat_en = 1'b0, ill = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    logic [3:0]  m_wmask = '0;
    logic        m_ar_up = 0, m_ar_done = 0, m_r_done = 0, m_aw_up = 0, m_aw_done = 0;
    logic        m_w_up = 0, m_w_done = 0, m_b_done = 0, m_seen_rsp = 0, idle_next = 0;
    int          cyc = 0, acc_cyc = 0, m_lat_exp = 0, obs_lat = 0, ar_hold = 0, rsp_count = 0;
    logic        w_before_aw = 0, last_err = 0;
    logic [31:0] obs_awaddr = '0, last_rdata = '0;
    logic [3:0]  obs_wstrb = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_illegal(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        return (a % (32'd1 << sz)) != 0;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_active = 0; m_seen_rsp = 0; idle_next = 0;
            m_ar_up = 0; m_aw_up = 0; m_w_up = 0;
        end else begin
            if (idle_next) begin
                chk("req_ready_after_rsp", req_ready, 1);
                idle_next = 0;
            end
            if (m_active) chk("req_ready_busy", req_ready, 0);
            if (m_active && m_ar_up && !m_ar_done) chk("arvalid_hold", arvalid, 1);
            if (m_active && m_aw_up && !m_aw_done) chk("awvalid_hold", awvalid, 1);
            if (m_active && m_w_up && !m_w_done)   chk("wvalid_hold", wvalid, 1);
            if (arvalid) begin
                chk("ar_allowed", m_active && m_bus && !m_wen && !m_ar_done, 1);
                chk("araddr", araddr, m_addr);
                m_ar_up = 1; ar_hold++;
            end
            if (rready) chk("rready_state", m_active && m_ar_done && !m_r_done, 1);
            if (awvalid) begin
                chk("aw_allowed", m_active && m_bus && m_wen && !m_aw_done, 1);
                chk("awaddr", awaddr, m_addr);
                m_aw_up = 1; obs_awaddr = awaddr;
            end
            if (wvalid) begin
                chk("w_allowed", m_active && m_bus && m_wen && !m_w_done, 1);
                chk("wdata", wdata, m_wdata);
                chk("wstrb", wstrb, m_wmask);
                m_w_up = 1; obs_wstrb = wstrb;
            end
            if (bready) chk("bready_state", m_active && m_aw_done && m_w_done && !m_b_done, 1);
            if (m_active && m_seen_rsp) chk("rsp_valid_hold", rsp_valid, 1);
            if (rsp_valid) begin
                chk("rsp_expected", m_active, 1);
                if (m_active) begin
                    chk("rsp_after_bus", !m_bus || m_r_done || m_b_done, 1);
                    chk("rsp_rdata", rsp_rdata, m_rdata);
                    chk("rsp_err", rsp_err, m_err);
                    if (!m_seen_rsp) begin
                        m_seen_rsp = 1;
                        obs_lat = cyc - acc_cyc;
                        if (m_lat_en || !m_bus) chk("latency", obs_lat, m_lat_exp);
                    end
                end
            end
        end

        // slave: each ready/valid rises after its configured number of waiting cycles
        arready = arvalid && (ar_cnt >= ar_dly);
        ar_cnt  = arvalid ? ar_cnt + 1 : 0;
        awready = awvalid && (aw_cnt >= aw_dly);
        aw_cnt  = awvalid ? aw_cnt + 1 : 0;
        wready  = wvalid && (w_cnt >= w_dly);
        w_cnt   = wvalid ? w_cnt + 1 : 0;
        rvalid  = rready && (r_cnt >= r_dly);
        r_cnt   = rready ? r_cnt + 1 : 0;
        rdata   = rvalid ? s_rdata : $urandom;
        rresp   = rvalid ? s_rresp : 2'($urandom);
        bvalid  = bready && (b_cnt >= b_dly);
        b_cnt   = bready ? b_cnt + 1 : 0;
        bresp   = bvalid ? s_bresp : 2'($urandom);

        if (rst_n) begin
            if (arvalid && arready) m_ar_done = 1;
            if (rready && rvalid)   m_r_done = 1;
            if (awvalid && awready) m_aw_done = 1;
            if (wvalid && wready) begin
                if (!m_aw_done) w_before_aw = 1;
                m_w_done = 1;
            end
            if (bready && bvalid) m_b_done = 1;
            if (rsp_valid && rsp_ready && m_active) begin
                m_active = 0; idle_next = 1; rsp_count++;
                last_rdata = rsp_rdata; last_err = rsp_err;
            end
            if (req_valid && req_ready) begin
                ill       = is_illegal(req_size, req_addr);
                m_active  = 1;
                m_wen     = req_wen;
                m_bus     = !ill && !(req_wen && req_wmask == 4'b0000);
                m_addr    = req_addr - (req_addr % 4);
                m_wdata   = req_wdata;
                m_wmask   = req_wmask;
                m_err     = ill ? 1'b1 : (!m_bus ? 1'b0 : (req_wen ? (s_bresp != 2'b00) : (s_rresp != 2'b00)));
                m_rdata   = (m_bus && !req_wen) ? s_rdata : 32'h0;
                m_lat_exp = m_bus ? 3 : 1;
                m_lat_en  = lat_chk;
                acc_cyc   = cyc;
                m_ar_up = 0; m_ar_done = 0; m_r_done = 0; m_aw_up = 0; m_aw_done = 0;
                m_w_up = 0; m_w_done = 0; m_b_done = 0; m_seen_rsp = 0;
                ar_hold = 0; w_before_aw = 0;
            end
        end
    end

    task automatic cfg(input int a, input int r, input int aw, input int w, input int b);
        ar_dly = a; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b;
    endtask

    task automatic send(input logic wen, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] wm);
        @(posedge clk); #1;
        req_valid = 1; req_wen = wen; req_size = sz; req_addr = a; req_wdata = wd; req_wmask = wm;
        for (int n = 0; n <= 100; n++) begin
            @(negedge clk);
            if (req_ready) break;
            if (n == 100) begin
                checks++; errors++;
                $display("FAIL req_accept_timeout: req_ready low for 100 cycles, required 1");
            end
        end
        @(posedge clk); #1;
        req_valid = 0; req_wen = 1'($urandom); req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_wmask = 4'($urandom);
    endtask

    task automatic wait_done(input logic rnd);
        for (int n = 0; n <= 300; n++) begin
            if (!m_active) break;
            if (n == 300) begin
                checks++; errors++;
                $display("FAIL rsp_timeout: transaction open after 300 cycles, required done");
                break;
            end
            if (rnd) rsp_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        rsp_ready = 1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        wen, zw;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [3:0]  wm;
        int          cnt0;

        #1 rst_n = 0;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1;

        // word load, arready delayed two cycles
        cfg(2, 0, 0, 0, 0); s_rdata = 32'hDEADBEEF; s_rresp = 2'b00; lat_chk = 0;
        send(0, 2'b10, 32'h8000_0004, 32'h0, 4'h0);
        wait_done(0);
        chk("t1_ar_hold", ar_hold, 3);
        chk("t1_rdata", last_rdata, 32'hDEADBEEF);
        chk("t1_err", last_err, 0);

        // byte store, W accepted before AW
        cfg(0, 0, 2, 0, 0); s_bresp = 2'b00; cnt0 = rsp_count;
        send(1, 2'b00, 32'h8000_0013, 32'hAB00_0000, 4'b1000);
        wait_done(0);
        chk("t2_awaddr", obs_awaddr, 32'h8000_0010);
        chk("t2_wstrb", obs_wstrb, 4'b1000);
        chk("t2_w_first", w_before_aw, 1);
        chk("t2_one_rsp", rsp_count - cnt0, 1);
        chk("t2_err", last_err, 0);

        // misaligned half and illegal size
        cfg(0, 0, 0, 0, 0);
        send(0, 2'b01, 32'h8000_0001, 32'h0, 4'h0);
        wait_done(0);
        chk("t3_half_lat", obs_lat, 1);
        chk("t3_half_err", last_err, 1);
        send(0, 2'b11, 32'h8000_0000, 32'h0, 4'h0);
        wait_done(0);
        chk("t3_sz11_lat", obs_lat, 1);
        chk("t3_sz11_err", last_err, 1);

        // empty-mask store
        send(1, 2'b10, 32'h8000_0040, 32'h1234_5678, 4'b0000);
        wait_done(0);
        chk("t4_lat", obs_lat, 1);
        chk("t4_err", last_err, 0);

        // SLVERR store with LSU back-pressure
        s_bresp = 2'b10; rsp_ready = 0;
        send(1, 2'b10, 32'h8000_0080, 32'hCAFE_F00D, 4'b1111);
        for (int n = 0; n < 50 && !rsp_valid; n++) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("t5_valid_held", rsp_valid, 1);
            chk("t5_err_held", rsp_err, 1);
            chk("t5_rdata_zero", rsp_rdata, 0);
            chk("t5_req_ready", req_ready, 0);
            @(negedge clk);
        end
        @(posedge clk); #1 rsp_ready = 1;
        wait_done(0);
        chk("t5_err", last_err, 1);
        s_bresp = 2'b00;

        // reset while waiting for read data
        cfg(0, 20, 0, 0, 0); s_rdata = 32'h5555_AAAA; cnt0 = rsp_count;
        send(0, 2'b10, 32'h8000_0020, 32'h0, 4'h0);
        for (int n = 0; n < 20 && !rready; n++) @(negedge clk);
        chk("t6_in_rd_data", rready, 1);
        #2 rst_n = 0;
        #1;
        chk("t6_rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
        chk("t6_rst_rsp_valid", rsp_valid, 0);
        chk("t6_rst_req_ready", req_ready, 0);
        chk("t6_rst_rdata", rsp_rdata, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        cfg(0, 0, 0, 0, 0); s_rdata = 32'h1234_5678; s_rresp = 2'b00; lat_chk = 1;
        send(0, 2'b10, 32'h8000_0008, 32'h0, 4'h0);
        wait_done(0);
        chk("t6_no_stale_rsp", rsp_count - cnt0, 1);
        chk("t6_rdata", last_rdata, 32'h1234_5678);
        chk("t6_lat", obs_lat, 3);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            wen = 1'($urandom);
            sz  = ($urandom_range(0, 7) == 7) ? 2'b11 : 2'($urandom_range(0, 2));
            a   = 32'h8000_0000 + ($urandom_range(0, 255) << 2) + (($urandom % 2 == 0) ? 0 : $urandom_range(0, 3));
            wm  = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
            zw  = ($urandom_range(0, 3) == 0);
            if (zw) cfg(0, 0, 0, 0, 0);
            else cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3));
            s_rdata = $urandom;
            s_rresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'b00;
            s_bresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'b00;
            lat_chk = zw;
            rsp_ready = 1;
            send(wen, sz, a, $urandom, wm);
            wait_done(!zw);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_25020047_lsu_axil_bridge.md
Name: ysyx_25020047_lsu_axil_bridge

Overview:
- Sits directly downstream of the LSU and replaces its direct pmem_read/pmem_write access with a registered AXI4-Lite master.
- Accepts one load or store request at a time from the LSU over a valid/ready handshake.
- Drives the AXI4-Lite AR/R or AW/W/B channels toward the memory/crossbar.
- Returns the raw 32-bit word and an error flag to the LSU. The LSU keeps lane extraction, sign/zero extension and store lane shifting.

Parameters:
- ADDR_W, 32, address width of the request and AXI address channels.
- DATA_W, 32, data width. Fixed at 32; wmask/wstrb width is DATA_W/8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  LSU request valid.
- req_ready  out  1  bridge can accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, already lane-aligned by the LSU.
- req_wmask  in  4  byte strobes for the store.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  LSU accepts the response.
- rsp_rdata  out  DATA_W  raw read word; 0 for stores.
- rsp_err  out  1  misalignment, illegal size, or non-OKAY bus response.
- araddr, arvalid, arready  out/out/in  ADDR_W/1/1  AXI read address channel.
- rdata, rresp, rvalid, rready  in/in/in/out  DATA_W/2/1/1  AXI read data channel.
- awaddr, awvalid, awready  out/out/in  ADDR_W/1/1  AXI write address channel.
- wdata, wstrb, wvalid, wready  out/out/out/in  DATA_W/4/1/1  AXI write data channel.
- bresp, bvalid, bready  in/in/out  2/1/1  AXI write response channel.

Behaviour:
- **Reset:**
  - rst_n low asynchronously forces state IDLE.
  - Forces all AXI valid/ready outputs, req_ready, rsp_valid and rsp_err to 0, and rsp_rdata to 0.
  - Reset mid-transaction abandons the transaction; no response is issued.
- **Outputs:** all outputs are registered; no combinational path from any input to any output.
- **States:** IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- **IDLE:**
  - req_ready=1.
  - On req_valid & req_ready, latch wen, size, addr, wdata and wmask; req_ready drops the next cycle.
  - Alignment check:
    - Illegal if size=11, size=01 with addr[0]=1, or size=10 with addr[1:0]!=0.
    - An illegal request goes to RESP with err=1 and generates no bus traffic.
  - Store with wmask=0000 goes to RESP with err=0 and generates no bus traffic.
  - Legal load goes to RD_ADDR; legal store goes to WR_REQ.
- **RD_ADDR:**
  - arvalid=1, araddr = latched address with bits [1:0] forced to 0.
  - arvalid stays held, with araddr stable, until arready; then go to RD_DATA.
- **RD_DATA:**
  - rready=1.
  - On rvalid, capture rdata into rsp_rdata and set err = (rresp != 00); go to RESP.
- **WR_REQ:**
  - awvalid and wvalid both assert on entry; awaddr is word-aligned; wstrb=wmask.
  - Each valid drops independently after its own handshake; AW and W may complete in either order or together.
  - Go to WR_RESP once both have completed.
- **WR_RESP:**
  - bready=1.
  - On bvalid, set err = (bresp != 00) and rsp_rdata=0; go to RESP.
- **RESP:**
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - On the handshake, rsp_valid drops and the state returns to IDLE; req_ready=1 on the following cycle.
- **Latency** (zero-wait slave, rsp_ready=1, request accepted at cycle 0):
  - Load: arvalid at cycle 1, rready at cycle 2, rsp_valid at cycle 3.
  - Store: AW/W at cycle 1, B at cycle 2, rsp_valid at cycle 3.
  - Error or empty-mask requests: rsp_valid at cycle 1.
- **Back-pressure:** at most one outstanding transaction. A new request is never accepted while rsp_valid is 1.
- **AXI rules:**
  - Once asserted, a valid is never deasserted before its handshake, and the address/data do not change while valid.
  - rready and bready are asserted only in their own states.
  - No timeout: the bridge waits indefinitely.

Decomposition:
- Shared package: state encoding (3-bit localparams), size codes (SZ_B/SZ_H/SZ_W), AXI response codes (OKAY=00, SLVERR=10, DECERR=11).
- One natural sub-module: ysyx_25020047_lsu_align_chk, a combinational size/address legality check, reusable by the IFU bridge.

Test Plan:
- Word load at addr 0x80000004, slave returns rdata=0xDEADBEEF with arready delayed 2 cycles -> araddr=0x80000004 held 3 cycles, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte store at addr 0x80000013, wdata=0xAB000000, wmask=1000, wready before awready -> wvalid drops first, awaddr=0x80000010, wstrb=1000, single response with rsp_err=0.
- Half load at addr 0x80000001 -> no arvalid at any cycle, rsp_valid at cycle 1, rsp_err=1; size=11 behaves the same.
- Store with wmask=0000 -> no AW/W traffic, rsp_valid=1, rsp_err=0.
- Slave returns bresp=10 on a word store -> rsp_err=1. rsp_ready held low 4 cycles -> rsp_valid/err stable, req_ready stays 0.
- rst_n asserted low while in RD_DATA -> all valids 0 immediately, no rsp_valid; after release, a new load completes normally.
